uart_rx_deserializer: RTL and testbench

//  - Receives the asynchronous 8N1 serial line from the host PC and deserializes it into bytes.
//  - Presents each byte as uart_data with a one-cycle uart_data_valid strobe.
//  - Sits directly upstream of the colour-command parser, which consumes uart_data/uart_data_valid.
//  - 16x oversampling, mid-bit sampling, start-glitch rejection and framing-error detection.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_baud_tick.sv | 44 ++++
 rtl/uart_rx_deserializer.sv | 215 +++++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART receive path.
//               Contains the receiver FSM state encodings, the idle line
//               level, and the ASCII command bytes understood by the
//               downstream colour-command parser.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  // Level of an idle (marking) serial line
  localparam logic IDLE_LEVEL = 1'b1;

  // Command bytes shared with the colour parser
  localparam logic [7:0] CMD_RED   = 8'h72;  // 'r'
  localparam logic [7:0] CMD_GREEN = 8'h67;  // 'g'
  localparam logic [7:0] CMD_BLUE  = 8'h62;  // 'b'
  localparam logic [7:0] CMD_WHITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_BLACK = 8'h42;  // 'B'
  localparam logic [7:0] ASCII_0   = 8'h30;  // '0'
  localparam logic [7:0] ASCII_9   = 8'h39;  // '9'
  localparam logic [7:0] ASCII_A   = 8'h41;  // 'A'
  localparam logic [7:0] ASCII_F   = 8'h46;  // 'F'

  // True when the byte is an upper-case hexadecimal digit character
  function automatic logic is_hex_ascii(input logic [7:0] c);
    return ((c >= ASCII_0) && (c <= ASCII_9)) || ((c >= ASCII_A) && (c <= ASCII_F));
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Free-running divider producing one sample_tick_o pulse every
//               DIVISOR clocks. restart_i synchronously reloads the count so
//               that sampling phase is aligned to a detected start edge.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int DIVISOR = 54
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic sample_tick_o
);

  localparam int            CW     = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at the terminal value, or reload on a restart request
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || (cnt_q == C_LAST)) begin
      cnt_d = '0;
    end
  end

  // Divider count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample_tick_o = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_deserializer
// Description : 8N1 UART receiver with oversampled mid-bit sampling, start
//               glitch rejection and framing-error detection. Emits each good
//               byte on uart_data with a single-cycle uart_data_valid strobe.
//               Optional macro UART_RX_PARITY_EN switches the frame to 8E1
//               and enables the parity_error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] uart_data,
  output logic       uart_data_valid,
  output logic       framing_error,
  output logic       parity_error
);

  localparam int            DIVISOR = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int            TW      = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] C_HALF  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] C_FULL  = TW'(OVERSAMPLE - 1);

  logic          sync1_q, sync2_q, rx_prev_q;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          fin_q, fin_stop_q;
  logic [7:0]    data_q;
  logic          valid_q, ferr_q, perr_q;

  logic rx_sync, fall_edge, sample_tick, mid_half, mid_full, par_ok;
  logic tick_restart, cnt_clr, cnt_inc, shift_en, finish;
`ifdef UART_RX_PARITY_EN
  logic par_en;
  logic par_bit_q;
`endif

  assign rx_sync   = sync2_q;
  assign fall_edge = rx_prev_q & ~sync2_q;
  assign mid_half  = sample_tick && (tick_cnt_q == C_HALF);
  assign mid_full  = sample_tick && (tick_cnt_q == C_FULL);

  uart_baud_tick #(
    .DIVISOR(DIVISOR)
  ) u_baud_tick (
    .clk          (clk),
    .reset        (reset),
    .restart_i    (tick_restart),
    .sample_tick_o(sample_tick)
  );

  // Two-flop synchronizer plus a delayed copy for start-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= IDLE_LEVEL;
      sync2_q   <= IDLE_LEVEL;
      rx_prev_q <= IDLE_LEVEL;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; leaves STOP at the mid-sample so back-to-back frames fit
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fall_edge) state_d = ST_START;
      ST_START:  if (mid_half) state_d = rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (mid_full && (bit_cnt_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (mid_full) state_d = ST_STOP;
`endif
      ST_STOP:   if (mid_full) state_d = rx_sync ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rx_sync) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: counter control, sampling strobes and frame completion
  always_comb begin
    tick_restart = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    shift_en     = 1'b0;
    finish       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        tick_restart = fall_edge;
        cnt_clr      = fall_edge;
      end
      ST_START: begin
        cnt_clr = mid_half;
        cnt_inc = sample_tick && !mid_half;
      end
      ST_DATA: begin
        shift_en = mid_full;
        cnt_clr  = mid_full;
        cnt_inc  = sample_tick && !mid_full;
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        par_en  = mid_full;
        cnt_clr = mid_full;
        cnt_inc = sample_tick && !mid_full;
      end
`endif
      ST_STOP: begin
        finish  = mid_full;
        cnt_clr = mid_full;
        cnt_inc = sample_tick && !mid_full;
      end
      default: ;
    endcase
  end

  // Sampling datapath: tick/bit counters, shift register, stop-bit capture
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      fin_q      <= 1'b0;
      fin_stop_q <= IDLE_LEVEL;
    end else begin
      if (cnt_clr) begin
        tick_cnt_q <= '0;
      end else if (cnt_inc) begin
        tick_cnt_q <= tick_cnt_q + TW'(1);
      end
      if (state_q != ST_DATA) begin
        bit_cnt_q <= '0;
      end else if (shift_en && (bit_cnt_q != 3'd7)) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (shift_en) begin
        shift_q <= {rx_sync, shift_q[7:1]};
      end
      fin_q <= finish;
      if (finish) begin
        fin_stop_q <= rx_sync;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Captured parity bit for the even-parity check
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bit_q <= 1'b0;
    end else if (par_en) begin
      par_bit_q <= rx_sync;
    end
  end

  assign par_ok = ~^{shift_q, par_bit_q};
`else
  assign par_ok = 1'b1;
`endif

  // Output registers: data is only replaced by a fully valid frame
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      valid_q <= fin_q & fin_stop_q & par_ok;
      ferr_q  <= fin_q & ~fin_stop_q;
      perr_q  <= fin_q & ~par_ok;
      if (fin_q && fin_stop_q && par_ok) begin
        data_q <= shift_q;
      end
    end
  end

  assign uart_data       = data_q;
  assign uart_data_valid = valid_q;
  assign framing_error   = ferr_q;
  assign parity_error    = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_deserializer
// Description : Self-checking bench for uart_rx_deserializer. A line driver
//               serialises frames while a reference model pushes the expected
//               receiver event per frame; an independent monitor pops and
//               compares every strobe the receiver produces.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deserializer;

  localparam int BIT = 864;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] uart_data;
  logic       uart_data_valid;
  logic       framing_error;
  logic       parity_error;

  typedef struct packed {
    logic       v;
    logic       f;
    logic       p;
    logic [7:0] d;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_exp;
  ev_t        mon_got;
  int         checks     = 0;
  int         errors     = 0;
  logic [7:0] model_last = 8'h00;

  always #5 clk = ~clk;

  uart_rx_deserializer dut (
    .clk            (clk),
    .reset          (reset),
    .rx             (rx),
    .uart_data      (uart_data),
    .uart_data_valid(uart_data_valid),
    .framing_error  (framing_error),
    .parity_error   (parity_error)
  );

  // Reference model: what one frame on the wire should produce
  function automatic ev_t model(input logic [7:0] d, input bit stop_good, input bit par_good);
    ev_t e;
    e.f = !stop_good;
    e.p = PAR_EN && !par_good;
    e.v = stop_good && (!PAR_EN || par_good);
    e.d = e.v ? d : 8'h00;
    return e;
  endfunction

  // Monitor: every strobe cycle must match the oldest expected event
  always @(negedge clk) begin
    if (!reset && (uart_data_valid || framing_error || parity_error)) begin
      mon_got = '{v: uart_data_valid, f: framing_error, p: parity_error,
                  d: uart_data_valid ? uart_data : 8'h00};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got v=%0b f=%0b p=%0b data=%02h, required no event",
                 mon_got.v, mon_got.f, mon_got.p, mon_got.d);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL event: got v=%0b f=%0b p=%0b data=%02h, required v=%0b f=%0b p=%0b data=%02h",
                   mon_got.v, mon_got.f, mon_got.p, mon_got.d,
                   mon_exp.v, mon_exp.f, mon_exp.p, mon_exp.d);
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h required %02h", name, act, req);
    end
  endtask

  task automatic line(input logic b, input int clks);
    rx = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_good, input bit par_good);
    ev_t e;
    e = model(d, stop_good, par_good);
    exp_q.push_back(e);
    if (e.v) model_last = d;
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(d[i], BIT);
    if (PAR_EN) line((^d) ^ !par_good, BIT);
    if (stop_good) line(1'b1, BIT);
    else line(1'b0, 2 * BIT);
    rx = 1'b1;
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] rnd;
    int         glitch;

    // Reset state
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cmp("reset_data", uart_data, 8'h00);
    cmp("reset_valid", {7'd0, uart_data_valid}, 8'h00);
    cmp("reset_ferr", {7'd0, framing_error}, 8'h00);
    cmp("reset_perr", {7'd0, parity_error}, 8'h00);
    line(1'b1, 100);

    // Single good frame
    send_frame(8'h72, 1'b1, 1'b1);
    line(1'b1, 200);
    cmp("hold_after_72", uart_data, model_last);

    // Short start glitch must be rejected
    glitch = $urandom_range(200, 350);
    line(1'b0, glitch);
    line(1'b1, 2 * BIT);
    cmp("hold_after_glitch", uart_data, model_last);

    // Stop bit held low: one framing error, data unchanged
    send_frame(8'h55, 1'b0, 1'b1);
    line(1'b1, BIT);
    cmp("hold_after_ferr", uart_data, model_last);

    send_frame(8'h47, 1'b1, 1'b1);
    line(1'b1, $urandom_range(0, 200));

    // Back-to-back frames, no idle between them
    send_frame(8'h47, 1'b1, 1'b1);
    send_frame(8'h36, 1'b1, 1'b1);
    send_frame(8'h57, 1'b1, 1'b1);
    line(1'b1, 200);
    cmp("hold_after_b2b", uart_data, model_last);

    // Reset in the middle of data bit 4 of 0xA5
    a5 = 8'hA5;
    line(1'b0, BIT);
    for (int i = 0; i < 4; i++) line(a5[i], BIT);
    line(a5[4], BIT / 2);
    reset = 1'b1;
    rx    = 1'b1;
    model_last = 8'h00;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    line(1'b1, BIT);
    cmp("data_after_reset", uart_data, model_last);

    send_frame(8'h42, 1'b1, 1'b1);
    line(1'b1, 200);
    cmp("hold_after_42", uart_data, model_last);

`ifdef UART_RX_PARITY_EN
    // Wrong parity then correct parity for the same byte
    send_frame(8'h31, 1'b1, 1'b0);
    line(1'b1, 200);
    cmp("hold_after_perr", uart_data, model_last);
    send_frame(8'h31, 1'b1, 1'b1);
    line(1'b1, 200);
    cmp("hold_after_31", uart_data, model_last);
`else
    // Random byte
    rnd = 8'($urandom);
    send_frame(rnd, 1'b1, 1'b1);
    line(1'b1, 200);
    cmp("hold_after_random", uart_data, model_last);
`endif

    // Drain: every expected event must have appeared
    for (int i = 0; (i < 4 * BIT) && (exp_q.size() != 0); i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d outstanding, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
